// File: rtl/npu_pkg.sv
// Shared definitions for the NPU sequencer: state encodings, SSFR bit
// positions and default sizing.
package npu_pkg;

  // State encodings; the enum below is built from these so that any
  // external decoder that wants the raw codes can use the same values.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_CLR    = 3'd2;
  localparam logic [2:0] ST_MAC    = 3'd3;
  localparam logic [2:0] ST_BIAS   = 3'd4;
  localparam logic [2:0] ST_WRITE  = 3'd5;
  localparam logic [2:0] ST_FINISH = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    CLR    = ST_CLR,
    MAC    = ST_MAC,
    BIAS   = ST_BIAS,
    WRITE  = ST_WRITE,
    FINISH = ST_FINISH
  } state_t;

  // SSFR configuration bits; the remaining bits are reserved.
  localparam int SSFR_RUN_BIT    = 0;
  localparam int SSFR_SINGLE_BIT = 1;

  // Default sizing of one layer pass.
  localparam int DEF_NUM_TAPS    = 4;
  localparam int DEF_NUM_NEURONS = 2;
  localparam int DEF_TIMEOUT_CYC = 64;

  // Counter widths: taps up to 16, neurons up to 4, stall up to 128.
  localparam int TAP_W    = 4;
  localparam int NEURON_W = 2;
  localparam int STALL_W  = 7;

endpackage

// File: rtl/npu_seq_cnt.sv
// Loadable up-counter with terminal-count flag. It saturates at term_val
// instead of wrapping, so a stuck enable can never roll the index over.
module npu_seq_cnt
  import npu_pkg::*;
#(
  parameter int WIDTH = TAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == term_val);

  // Count register: load has priority over counting, counting stops at term_val.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !tc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/npu_seq_ctrl.sv
// Moore sequencer for one NPU layer pass: latch inputs, then per neuron
// clear / MAC over every tap / bias add / FIFO write, then a DONE pulse.
// Optional build macro NPU_SEQ_TIMEOUT_EN adds a write-stall timeout that
// drops the stuck result and raises the sticky ERR flag.
module npu_seq_ctrl
  import npu_pkg::*;
#(
  parameter int NUM_TAPS    = DEF_NUM_TAPS,
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                CLKEXT,
  input  logic                RST_GLO,
  input  logic                START,
  input  logic [15:0]         SSFR,
  input  logic                FIFO_FULL,
  output logic                LOAD_IN,
  output logic                MAC_CLR,
  output logic                MAC_EN,
  output logic [TAP_W-1:0]    TAP_SEL,
  output logic [NEURON_W-1:0] NEURON_SEL,
  output logic                BIAS_ADD,
  output logic                FIFO_WR,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
);

  localparam logic [TAP_W-1:0]    TAP_LAST    = TAP_W'(NUM_TAPS - 1);
  localparam logic [NEURON_W-1:0] NEURON_LAST = NEURON_W'(NUM_NEURONS - 1);

  state_t              state;
  state_t              next_state;
  logic [TAP_W-1:0]    tap_cnt;
  logic                tap_tc;
  logic [NEURON_W-1:0] neuron_q;
  logic                single_q;
  logic                wr_q;
  logic                start_ok;
  logic                last_hit;
  logic                timeout_hit;
  logic                write_leave;
  logic                ssfr_unused;

  assign ssfr_unused = ^SSFR[15:2];

  assign start_ok    = START && SSFR[SSFR_RUN_BIT];
  assign last_hit    = (neuron_q == (single_q ? '0 : NEURON_LAST));
  assign write_leave = (state == WRITE) && (!FIFO_FULL || timeout_hit);

  assign TAP_SEL    = tap_cnt;
  assign NEURON_SEL = neuron_q;

  // The write strobe is armed by the registered WRITE decode and released the
  // same cycle FIFO_FULL drops, so a freed FIFO is written without a wait cycle.
  // Reset masks it so an aborted pass never pushes a partial result.
  assign FIFO_WR = wr_q && !FIFO_FULL && !RST_GLO;

  // Tap index: held at 0 outside MAC, counts once per MAC cycle.
  npu_seq_cnt #(.WIDTH(TAP_W)) u_tap_cnt (
    .clk      (CLKEXT),
    .rst      (RST_GLO),
    .load     (state != MAC),
    .load_val ('0),
    .en       (state == MAC),
    .term_val (TAP_LAST),
    .count    (tap_cnt),
    .tc       (tap_tc)
  );

`ifdef NPU_SEQ_TIMEOUT_EN
  logic [STALL_W-1:0] stall_cnt_unused;
  logic               stall_tc;
  logic               err_q;

  // Stall counter: counts full cycles spent in WRITE, cleared outside WRITE.
  npu_seq_cnt #(.WIDTH(STALL_W)) u_stall_cnt (
    .clk      (CLKEXT),
    .rst      (RST_GLO),
    .load     (state != WRITE),
    .load_val ('0),
    .en       ((state == WRITE) && FIFO_FULL),
    .term_val (STALL_W'(TIMEOUT_CYC - 1)),
    .count    (stall_cnt_unused),
    .tc       (stall_tc)
  );

  // Terminal count means this is the TIMEOUT_CYC-th stalled cycle.
  assign timeout_hit = (state == WRITE) && FIFO_FULL && stall_tc;
  assign ERR         = err_q;
`else
  logic timeout_cfg_unused;

  assign timeout_cfg_unused = (TIMEOUT_CYC > 0);
  assign timeout_hit        = 1'b0;
  assign ERR                = 1'b0;
`endif

  // Next-state logic of the pass sequencer.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    next_state = state;
    case (state)
      IDLE:    if (start_ok) next_state = LOAD;
      LOAD:    next_state = CLR;
      CLR:     next_state = MAC;
      MAC:     if (tap_tc) next_state = BIAS;
      BIAS:    next_state = WRITE;
      WRITE:   if (write_leave) next_state = last_hit ? FINISH : CLR;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, neuron bookkeeping and outputs registered from the state being entered.
  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      state    <= IDLE;
      neuron_q <= '0;
      single_q <= 1'b0;
      LOAD_IN  <= 1'b0;
      MAC_CLR  <= 1'b0;
      MAC_EN   <= 1'b0;
      BIAS_ADD <= 1'b0;
      wr_q     <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
`ifdef NPU_SEQ_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state    <= next_state;
      LOAD_IN  <= (next_state == LOAD);
      MAC_CLR  <= (next_state == CLR);
      MAC_EN   <= (next_state == MAC);
      BIAS_ADD <= (next_state == BIAS);
      wr_q     <= (next_state == WRITE);
      BUSY     <= (next_state != IDLE);
      DONE     <= (next_state == FINISH);

      if (state == IDLE && start_ok) begin
        neuron_q <= '0;
      end else if (write_leave && !last_hit) begin
        neuron_q <= neuron_q + NEURON_W'(1);
      end

      if (state == LOAD) begin
        single_q <= SSFR[SSFR_SINGLE_BIT];
      end

`ifdef NPU_SEQ_TIMEOUT_EN
      if (state == IDLE && start_ok) begin
        err_q <= 1'b0;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end
`endif
    end
  end

endmodule
